// File: rtl/tohost_monitor_pkg.sv
// rtl/tohost_monitor_pkg.sv - shared encodings and helpers for the tohost completion monitor
//   Purpose: monitor state encodings, default tohost address, tohost hit decode.
//   Ports:   none (package).
package tohost_monitor_pkg;

   typedef enum logic [2:0] {
      MON_RUN     = 3'd0,
      MON_PASS    = 3'd1,
      MON_FAIL    = 3'd2,
      MON_TIMEOUT = 3'd3,
      MON_HANG    = 3'd4
   } mon_state_e;

   localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

   // Only full-word writes count; byte lanes within the word are not checked by address.
   function automatic logic is_tohost_hit(input logic        valid,
                                          input logic [29:0] word_addr,
                                          input logic [3:0]  be,
                                          input logic [29:0] tohost_word);
      return valid && (word_addr == tohost_word) && (be == 4'hF);
   endfunction

endpackage

// File: rtl/tohost_monitor_sat_counter.sv
// rtl/tohost_monitor_sat_counter.sv - saturating up-counter with synchronous clear
//   Purpose: counts up on en, sticks at all-ones, clr has priority over en.
//   Ports:   clk, rst (async, active-low), clr, en, q[W-1:0].
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en && (q_q != '1)) begin
         q_d = q_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/tohost_monitor.sv
// rtl/tohost_monitor.sv - riscv-tests tohost completion monitor
//   Purpose: snoops core stores and retires; reports PASS/FAIL from tohost,
//            TIMEOUT and HANG otherwise; exposes cycle/instret counters.
//   Ports:   clk, rst (async, active-low); st_valid/st_addr/st_data/st_be store snoop;
//            rt_valid/rt_pc retire snoop; done/pass/fail/timeout/hang/test_num result;
//            cycles/instret counters.
module tohost_monitor
   import tohost_monitor_pkg::*;
#(
   parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEFAULT,
   parameter int          TIMEOUT_CYCLES = 5000,
   parameter int          STALL_LIMIT    = 64,
   parameter int          CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             st_valid,
   input  logic [31:0]      st_addr,
   input  logic [31:0]      st_data,
   input  logic [3:0]       st_be,
   input  logic             rt_valid,
   input  logic [31:0]      rt_pc,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic             hang,
   output logic [30:0]      test_num,
   output logic [CNT_W-1:0] cycles,
   output logic [CNT_W-1:0] instret
);

   localparam int LW = $clog2(STALL_LIMIT + 1);

   mon_state_e state_q, state_d;
   logic [31:0] prev_pc_q, prev_pc_d;
   logic        prev_valid_q, prev_valid_d;
   logic        done_q, done_d, pass_q, pass_d, fail_q, fail_d;
   logic        timeout_q, timeout_d, hang_q, hang_d;
   logic [30:0] test_num_q, test_num_d;

   logic [CNT_W-1:0] cycles_cnt, instret_cnt;
   logic [LW-1:0]    loop_cnt, idle_cnt;

   logic run, hit, same_pc, loop_hang, idle_hang, timeout_hit;
   logic unused_addr_bits;

   assign unused_addr_bits = ^st_addr[1:0];

   assign run     = (state_q == MON_RUN);
   assign hit     = is_tohost_hit(st_valid, st_addr[31:2], st_be, TOHOST_ADDR[31:2]);
   // The first retire after reset only seeds prev_pc and never counts as a loop.
   assign same_pc = rt_valid && prev_valid_q && (rt_pc == prev_pc_q);

   // Fire on the event that brings a counter up to the limit, so HANG lands next cycle.
   assign loop_hang   = same_pc && (loop_cnt == LW'(STALL_LIMIT - 1));
   assign idle_hang   = !rt_valid && (idle_cnt == LW'(STALL_LIMIT - 1));
   assign timeout_hit = (cycles_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   sat_counter #(.W(CNT_W)) u_cycles (
      .clk(clk), .rst(rst), .clr(1'b0), .en(run), .q(cycles_cnt));

   sat_counter #(.W(CNT_W)) u_instret (
      .clk(clk), .rst(rst), .clr(1'b0), .en(run && rt_valid), .q(instret_cnt));

   sat_counter #(.W(LW)) u_loop_cnt (
      .clk(clk), .rst(rst), .clr(rt_valid && !same_pc), .en(run && same_pc), .q(loop_cnt));

   sat_counter #(.W(LW)) u_idle_cnt (
      .clk(clk), .rst(rst), .clr(rt_valid), .en(run && !rt_valid), .q(idle_cnt));

   always_comb begin
      state_d      = state_q;
      test_num_d   = test_num_q;
      prev_pc_d    = prev_pc_q;
      prev_valid_d = prev_valid_q;
      if (run) begin
         if (rt_valid) begin
            prev_pc_d    = rt_pc;
            prev_valid_d = 1'b1;
         end
         // Priority: tohost result > hang > timeout. Even tohost values fall through.
         if (hit && (st_data == 32'h1)) begin
            state_d = MON_PASS;
         end else if (hit && st_data[0]) begin
            state_d    = MON_FAIL;
            test_num_d = st_data[31:1];
         end else if (loop_hang || idle_hang) begin
            state_d = MON_HANG;
         end else if (timeout_hit) begin
            state_d = MON_TIMEOUT;
         end
      end
      done_d    = (state_d != MON_RUN);
      pass_d    = (state_d == MON_PASS);
      fail_d    = (state_d == MON_FAIL);
      timeout_d = (state_d == MON_TIMEOUT);
      hang_d    = (state_d == MON_HANG);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= MON_RUN;
         test_num_q   <= '0;
         prev_pc_q    <= '0;
         prev_valid_q <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         timeout_q    <= 1'b0;
         hang_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         test_num_q   <= test_num_d;
         prev_pc_q    <= prev_pc_d;
         prev_valid_q <= prev_valid_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         timeout_q    <= timeout_d;
         hang_q       <= hang_d;
      end
   end

   assign done     = done_q;
   assign pass     = pass_q;
   assign fail     = fail_q;
   assign timeout  = timeout_q;
   assign hang     = hang_q;
   assign test_num = test_num_q;
   assign cycles   = cycles_cnt;
   assign instret  = instret_cnt;

endmodule

// File: tb/tb_tohost_monitor.sv
// tb/tb_tohost_monitor.sv - directed self-checking bench for tohost_monitor
module tb_tohost_monitor;

   logic        clk;
   logic        rst;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [3:0]  st_be;
   logic        rt_valid;
   logic [31:0] rt_pc;
   logic        done, pass, fail, timeout, hang;
   logic [30:0] test_num;
   logic [31:0] cycles, instret;

   logic [31:0] pc_r;
   int          n_vec;
   int          n_err;

   tohost_monitor #(
      .TOHOST_ADDR(32'h0000_1000),
      .TIMEOUT_CYCLES(100),
      .STALL_LIMIT(64),
      .CNT_W(32)
   ) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
      .rt_valid(rt_valid), .rt_pc(rt_pc),
      .done(done), .pass(pass), .fail(fail), .timeout(timeout), .hang(hang),
      .test_num(test_num), .cycles(cycles), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic apply(input logic sv, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic rv, input logic [31:0] pc);
      st_valid = sv;
      st_addr  = addr;
      st_data  = data;
      st_be    = be;
      rt_valid = rv;
      rt_pc    = pc;
      @(posedge clk);
      #1;
      st_valid = 1'b0;
      rt_valid = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         apply(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, pc_r);
         pc_r = pc_r + 32'd4;
      end
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      apply(1'b1, addr, data, be, 1'b1, pc_r);
      pc_r = pc_r + 32'd4;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
   endtask

   // Called at posedge+1; reset pulse stays clear of the next edge, which becomes cycle 0.
   task automatic restart();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      pc_r = 32'h8000_0000;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b0;
      st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
      rt_valid = 1'b0; rt_pc = '0;
      pc_r = 32'h8000_0000;
      repeat (2) @(posedge clk);
      #1;
      check_vec("rst_done", 64'(done), 64'd0);
      check_vec("rst_pass", 64'(pass), 64'd0);
      check_vec("rst_cycles", 64'(cycles), 64'd0);
      check_vec("rst_instret", 64'(instret), 64'd0);
      rst = 1'b1;

      // PASS on cycle 10
      run(10);
      check_vec("pre_pass_done", 64'(done), 64'd0);
      check_vec("pre_pass_cycles", 64'(cycles), 64'd10);
      store(32'h1000, 32'h1, 4'hF);
      check_vec("pass_flag", 64'(pass), 64'd1);
      check_vec("pass_done", 64'(done), 64'd1);
      check_vec("pass_cycles", 64'(cycles), 64'd11);
      check_vec("pass_instret", 64'(instret), 64'd11);
      check_vec("pass_others", 64'({fail, timeout, hang}), 64'd0);
      run(5);
      check_vec("pass_cycles_frozen", 64'(cycles), 64'd11);
      check_vec("pass_instret_frozen", 64'(instret), 64'd11);

      // FAIL with test 3, later PASS store ignored
      restart();
      run(3);
      store(32'h1000, 32'h7, 4'hF);
      check_vec("fail_flag", 64'(fail), 64'd1);
      check_vec("fail_test_num", 64'(test_num), 64'd3);
      check_vec("fail_pass", 64'(pass), 64'd0);
      store(32'h1000, 32'h1, 4'hF);
      check_vec("fail_then_pass", 64'({pass, fail}), 64'b01);

      // Ignored tohost writes
      restart();
      store(32'h1000, 32'h2, 4'hF);
      store(32'h1000, 32'h0, 4'hF);
      store(32'h1000, 32'h1, 4'h1);
      store(32'h1004, 32'h1, 4'hF);
      check_vec("ignored_done", 64'(done), 64'd0);
      store(32'h1000, 32'h1, 4'hF);
      check_vec("ignored_then_pass", 64'(pass), 64'd1);

      // TIMEOUT at cycle 100
      restart();
      run(99);
      check_vec("pre_timeout_done", 64'(done), 64'd0);
      run(1);
      check_vec("timeout_flag", 64'(timeout), 64'd1);
      check_vec("timeout_cycles", 64'(cycles), 64'd100);
      check_vec("timeout_others", 64'({pass, fail, hang, done}), 64'b0001);
      run(10);
      check_vec("timeout_cycles_frozen", 64'(cycles), 64'd100);

      // tohost on the timeout cycle wins
      restart();
      run(99);
      store(32'h1000, 32'h1, 4'hF);
      check_vec("pass_over_timeout", 64'({pass, timeout}), 64'b10);
      check_vec("pass_over_timeout_cycles", 64'(cycles), 64'd100);

      // Self-loop HANG: first retire seeds, 64 further repeats trigger
      restart();
      for (int i = 0; i < 64; i++) apply(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h80);
      check_vec("pre_loop_hang", 64'(hang), 64'd0);
      apply(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h80);
      check_vec("loop_hang", 64'({hang, done}), 64'b11);
      check_vec("loop_hang_cycles", 64'(cycles), 64'd65);

      // Loops broken by a PC change never accumulate
      restart();
      for (int i = 0; i < 40; i++) apply(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h80);
      for (int i = 0; i < 40; i++) apply(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h84);
      check_vec("loop_break_done", 64'(done), 64'd0);

      // Starvation HANG after 64 idle cycles
      restart();
      idle(63);
      check_vec("pre_idle_hang", 64'(hang), 64'd0);
      idle(1);
      check_vec("idle_hang", 64'(hang), 64'd1);
      check_vec("idle_hang_cycles", 64'(cycles), 64'd64);
      check_vec("idle_hang_instret", 64'(instret), 64'd0);

      // tohost beats HANG in the same cycle
      restart();
      idle(63);
      apply(1'b1, 32'h1000, 32'h1, 4'hF, 1'b0, 32'h0);
      check_vec("pass_over_hang", 64'({pass, hang}), 64'b10);

      // Asynchronous reset mid-run, then in PASS
      restart();
      run(20);
      #3;
      rst = 1'b0;
      #1;
      check_vec("midrun_rst_cycles", 64'(cycles), 64'd0);
      check_vec("midrun_rst_instret", 64'(instret), 64'd0);
      #1;
      rst = 1'b1;
      pc_r = 32'h8000_0000;
      run(5);
      check_vec("after_rst_cycles", 64'(cycles), 64'd5);
      store(32'h1000, 32'h1, 4'hF);
      check_vec("after_rst_pass", 64'(pass), 64'd1);
      #3;
      rst = 1'b0;
      #1;
      check_vec("pass_rst_flags", 64'({done, pass, fail, timeout, hang}), 64'd0);
      check_vec("pass_rst_cycles", 64'(cycles), 64'd0);
      #1;
      rst = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
